block_data_memory: RTL

BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

---
 rtl/block_data_memory_if.sv | 25 ++
 rtl/block_data_memory.sv | 99 +++++++++
 2 files changed

// File: rtl/block_data_memory_if.sv
// Request/response bundle between a requester and block_data_memory.
// The requester drives the request fields; the memory drives readdata, busywait and error.
interface block_data_memory_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_BYTES = 4
);
    logic                     read;
    logic                     write;
    logic [ADDR_WIDTH-1:0]    address;
    logic [8*BLOCK_BYTES-1:0] writedata;
    logic [BLOCK_BYTES-1:0]   byteenable;
    logic [8*BLOCK_BYTES-1:0] readdata;
    logic                     busywait;
    logic                     error;

    modport master (
        output read, write, address, writedata, byteenable,
        input  readdata, busywait, error
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output readdata, busywait, error
    );
endinterface

// File: rtl/block_data_memory.sv
// Block-organised data memory with a fixed access latency and per-byte write enables.
//
// state | meaning
// IDLE  | waiting for exactly one of read/write; both at once flags error
// BUSY  | counting down the access latency on the latched request
// DONE  | access finished; requests ignored for one cycle
module block_data_memory #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BLOCK_BYTES = 4,
    parameter int LATENCY     = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    block_data_memory_if.slave      bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int DW    = 8*BLOCK_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q;
    logic [7:0]                     cnt_q;
    logic                           op_wr_q;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [DW-1:0]                  wdata_q;
    logic [BLOCK_BYTES-1:0]         be_q;
    logic [DW-1:0]                  rdata_q;
    logic                           error_q;
    logic [BLOCK_BYTES-1:0][7:0]    mem_q [DEPTH];

    logic req_one;
    logic req_both;

    assign req_one  = bus.read ^ bus.write;
    assign req_both = bus.read & bus.write;

    // Gated by reset so a held request cannot raise busywait while reset is low.
    assign bus.busywait = reset && ((state_q == BUSY) || ((state_q == IDLE) && req_one));
    assign bus.readdata = rdata_q;
    assign bus.error    = error_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_one) begin
                        op_wr_q <= bus.write;
                        addr_q  <= bus.address;
                        wdata_q <= bus.writedata;
                        be_q    <= bus.byteenable;
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= BUSY;
                    end else if (req_both) begin
                        error_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        if (op_wr_q) begin
                            for (int k = 0; k < BLOCK_BYTES; k++) begin
                                if (be_q[k]) begin
                                    mem_q[addr_q][k] <= wdata_q[8*k +: 8];
                                end
                            end
                        end else begin
                            rdata_q <= mem_q[addr_q];
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
